circuit_1_sched: RTL and testbench



---
 rtl/circuit_1_sched_pkg.sv | 15 +
 rtl/circuit_1_sched_alu.sv | 18 +
 rtl/circuit_1_sched.sv | 133 +++++++++++++
 tb/tb_circuit_1_sched.sv | 132 +++++++++++++
 4 files changed

// File: rtl/circuit_1_sched_pkg.sv
// Shared types for the scheduled circuit_1 datapath: FSM states and ALU op codes.
package circuit_1_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_ADD1 = 3'd1,
        S_ADD2 = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/circuit_1_sched_alu.sv
// Shared add/sub unit; the single arithmetic resource time-multiplexed by the FSM.
module sched_alu
    import circuit_1_sched_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         op_i,
    input  logic [W-1:0] lhs_i,
    input  logic [W-1:0] rhs_i,
    output logic [W-1:0] res_o
);

    always_comb begin
        if (op_i == ALU_SUB) res_o = lhs_i - rhs_i;
        else                 res_o = lhs_i + rhs_i;
    end

endmodule

// File: rtl/circuit_1_sched.sv
// HLS-style scheduled circuit_1: one shared ALU and one multiplier sequenced over
// four busy cycles; results are registered and held until the next completion.
module circuit_1_sched
    import circuit_1_sched_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATAWIDTH-1:0]   a,
    input  logic [DATAWIDTH-1:0]   b,
    input  logic [DATAWIDTH-1:0]   c,
    output logic                   busy,
    output logic                   done,
    output logic [DATAWIDTH-1:0]   z,
    output logic [2*DATAWIDTH-1:0] x
);

    localparam int XW = 2 * DATAWIDTH;

    state_t state_q, state_d;

    logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, z_q, z_d;
    logic [XW-1:0]        f_q, f_d, x_q, x_d;

    logic          alu_op;
    logic [XW-1:0] alu_lhs, alu_rhs, alu_res;
    logic [XW-1:0] mul_res;

    // Operand muxes steer the shared ALU according to the current schedule step.
    always_comb begin
        alu_op  = ALU_ADD;
        alu_lhs = {{DATAWIDTH{1'b0}}, a_q};
        alu_rhs = {{DATAWIDTH{1'b0}}, b_q};
        case (state_q)
            S_ADD2: alu_rhs = {{DATAWIDTH{1'b0}}, c_q};
            S_FIN: begin
                alu_op  = ALU_SUB;
                alu_lhs = f_q;
                alu_rhs = {{DATAWIDTH{1'b0}}, d_q};
            end
            default: ;
        endcase
    end

    sched_alu #(.W(XW)) u_alu (
        .op_i  (alu_op),
        .lhs_i (alu_lhs),
        .rhs_i (alu_rhs),
        .res_o (alu_res)
    );

    assign mul_res = {{DATAWIDTH{1'b0}}, a_q} * {{DATAWIDTH{1'b0}}, c_q};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = S_ADD1;
            S_ADD1:  state_d = S_ADD2;
            S_ADD2:  state_d = S_FIN;
            S_FIN:   state_d = S_DONE;
            S_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath next-state: each register only moves in its scheduled step.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        e_d = e_q;
        f_d = f_q;
        z_d = z_q;
        x_d = x_q;
        case (state_q)
            IDLE: if (start) begin
                a_d = a;
                b_d = b;
                c_d = c;
            end
            S_ADD1: begin
                d_d = alu_res[DATAWIDTH-1:0];
                f_d = mul_res;
            end
            S_ADD2: e_d = alu_res[DATAWIDTH-1:0];
            S_FIN: begin
                x_d = alu_res;
                z_d = (d_q > e_q) ? e_q : d_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
            e_q <= '0;
            f_q <= '0;
            z_q <= '0;
            x_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            d_q <= d_d;
            e_q <= e_d;
            f_q <= f_d;
            z_q <= z_d;
            x_q <= x_d;
        end
    end

    assign z = z_q;
    assign x = x_q;

endmodule

// File: tb/tb_circuit_1_sched.sv
// Directed + random bench for circuit_1_sched against a plain-arithmetic reference.
module tb_circuit_1_sched;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  a, b, c;
    logic        busy, done;
    logic [7:0]  z;
    logic [15:0] x;

    int total = 0;
    int bad   = 0;
    int exp_z = 0;
    int exp_x = 0;

    circuit_1_sched #(.DATAWIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .x     (x)
    );

    always #5 clk = ~clk;

    function automatic int ref_z(int ia, int ib, int ic);
        int d = (ia + ib) % 256;
        int e = (ia + ic) % 256;
        return (d > e) ? e : d;
    endfunction

    function automatic int ref_x(int ia, int ib, int ic);
        int d = (ia + ib) % 256;
        return (ia * ic - d + 65536) % 65536;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Caller is at a negedge in IDLE. Leaves us at the negedge of the IDLE cycle after done.
    task automatic op(input int ia, input int ib, input int ic, input bit hold_start);
        a = 8'(ia); b = 8'(ib); c = 8'(ic); start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            chk("busy", 32'(busy), 1);
            chk("done", 32'(done), (k == 4) ? 1 : 0);
            if (k == 4) begin
                exp_z = ref_z(ia, ib, ic);
                exp_x = ref_x(ia, ib, ic);
            end
            chk("z", 32'(z), exp_z);
            chk("x", 32'(x), exp_x);
            @(negedge clk);
        end
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_z", 32'(z), 0);
        chk("rst_x", 32'(x), 0);
        rst = 1'b0;

        // No start: remains idle.
        repeat (3) @(negedge clk);
        chk("nostart_busy", 32'(busy), 0);

        op(10, 20, 5, 1'b0);
        chk("basic_z", 32'(z), 15);
        chk("basic_x", 32'(x), 20);
        op(200, 100, 3, 1'b0);
        chk("ovf_z", 32'(z), 44);
        chk("ovf_x", 32'(x), 556);
        op(1, 250, 1, 1'b0);
        chk("unf_z", 32'(z), 2);
        chk("unf_x", 32'(x), 65286);

        // Tie with start held through the whole op; the follow-on op starts in the IDLE cycle.
        op(7, 7, 7, 1'b1);
        chk("tie_z", 32'(z), 14);
        chk("tie_x", 32'(x), 35);
        op(9, 3, 4, 1'b0);

        // Reset during S_ADD2 aborts with cleared outputs and no done.
        a = 8'd50; b = 8'd60; c = 8'd70; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_z", 32'(z), 0);
        chk("abort_x", 32'(x), 0);
        for (int k = 0; k < 4; k++) begin
            chk("abort_nodone", 32'(done), 0);
            @(negedge clk);
        end
        exp_z = 0; exp_x = 0;
        op(10, 20, 5, 1'b0);
        chk("post_rst_z", 32'(z), 15);
        chk("post_rst_x", 32'(x), 20);

        // Back-to-back random operations; op() checks holding of previous results.
        for (int n = 0; n < 25; n++)
            op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), n[0]);
        start = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
